// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, frame edge numbers and
// default cycle counts for a 50 MHz system clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRequest,
        StWaitStart,
        StSend,
        StWaitIdle,
        StFail
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_EDGE = 10;
    localparam int unsigned ACK_EDGE  = 11;

    localparam int unsigned DEF_INHIBIT_CYCLES       = 6000;
    localparam int unsigned DEF_START_TIMEOUT_CYCLES = 750000;
    localparam int unsigned DEF_XFER_TIMEOUT_CYCLES  = 100000;
    localparam int unsigned DEF_CNT_W                = 20;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] i_byte);
        return ~^i_byte;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock; usable by both transmit and receive paths.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_sync,
    output logic o_dat_sync,
    output logic o_clk_fall
);

    logic [1:0] r_clk_ff;
    logic [1:0] r_dat_ff;
    logic       r_clk_prev;

    // Reset to the idle (released) line level so no edge is reported after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_ff   <= 2'b11;
            r_dat_ff   <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_ff   <= {r_clk_ff[0], i_ps2_clk};
            r_dat_ff   <= {r_dat_ff[0], i_ps2_dat};
            r_clk_prev <= r_clk_ff[1];
        end
    end

    assign o_clk_sync = r_clk_ff[1];
    assign o_dat_sync = r_dat_ff[1];
    assign o_clk_fall = r_clk_prev & ~r_clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocks out
// 8 data bits + odd parity + stop on device falling edges, then checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W                = DEF_CNT_W
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 send_command,
    input  logic [DATA_BITS-1:0] command_data,
    input  logic                 ps2_clk_in,
    input  logic                 ps2_dat_in,
    output logic                 ps2_clk_drive_low,
    output logic                 ps2_dat_drive_low,
    output logic                 busy,
    output logic                 command_done,
    output logic                 error
);

    // The FAIL state and the registered error pulse add two cycles, so both
    // timeouts compare two short of the budget to land the pulse on the count.
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

    tx_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [3:0]         r_edge_cnt, w_edge_nxt;
    logic [DATA_BITS:0] r_shift, w_shift_nxt;
    logic               r_clk_low, w_clk_low_nxt;
    logic               r_dat_low, w_dat_low_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_error, w_error_nxt;

    logic w_clk_sync;
    logic w_dat_sync;
    logic w_clk_fall;

    ps2_sync_edge u_sync (
        .i_clk      (CLOCK_50),
        .i_rst      (reset),
        .i_ps2_clk  (ps2_clk_in),
        .i_ps2_dat  (ps2_dat_in),
        .o_clk_sync (w_clk_sync),
        .o_dat_sync (w_dat_sync),
        .o_clk_fall (w_clk_fall)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= StIdle;
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_shift    <= '0;
            r_clk_low  <= 1'b0;
            r_dat_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_shift    <= w_shift_nxt;
            r_clk_low  <= w_clk_low_nxt;
            r_dat_low  <= w_dat_low_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer + TIMER_ONE;
        w_edge_nxt    = r_edge_cnt;
        w_shift_nxt   = r_shift;
        w_dat_low_nxt = r_dat_low;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_timer_nxt = '0;
                if (send_command) begin
                    w_state_nxt = StInhibit;
                    w_shift_nxt = {odd_parity(command_data), command_data};
                    w_edge_nxt  = '0;
                end
            end
            StInhibit: begin
                if (r_timer == INH_LAST) begin
                    w_state_nxt   = StRequest;
                    w_timer_nxt   = '0;
                    w_dat_low_nxt = 1'b1;
                end
            end
            StRequest: w_state_nxt = StWaitStart;
            StWaitStart: begin
                if (w_clk_fall) begin
                    w_state_nxt   = StSend;
                    w_timer_nxt   = '0;
                    w_edge_nxt    = 4'd1;
                    w_dat_low_nxt = ~r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                end else if (r_timer == START_LAST) begin
                    w_state_nxt = StFail;
                end
            end
            StSend: begin
                if (r_timer == XFER_LAST) begin
                    w_state_nxt = StFail;
                end else if (w_clk_fall) begin
                    w_edge_nxt = r_edge_cnt + 4'd1;
                    if (r_edge_cnt == 4'(ACK_EDGE - 1)) begin
                        w_state_nxt = w_dat_sync ? StFail : StWaitIdle;
                    end else if (r_edge_cnt == 4'(STOP_EDGE - 1)) begin
                        w_dat_low_nxt = 1'b0;
                    end else begin
                        w_dat_low_nxt = ~r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                    end
                end
            end
            StWaitIdle: begin
                if (r_timer == XFER_LAST) begin
                    w_state_nxt = StFail;
                end else if (w_clk_sync && w_dat_sync) begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            StFail: begin
                w_state_nxt = StIdle;
                w_error_nxt = 1'b1;
            end
            default: w_state_nxt = StIdle;
        endcase

        // Line drives follow the state being entered so the outputs stay registered.
        w_clk_low_nxt = (w_state_nxt == StInhibit) || (w_state_nxt == StRequest);
        if (!((w_state_nxt == StRequest) || (w_state_nxt == StWaitStart) ||
              (w_state_nxt == StSend))) begin
            w_dat_low_nxt = 1'b0;
        end
        w_busy_nxt = (w_state_nxt != StIdle);
    end

    assign ps2_clk_drive_low = r_clk_low;
    assign ps2_dat_drive_low = r_dat_low;
    assign busy              = r_busy;
    assign command_done      = r_done;
    assign error             = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table of full transfers against a PS/2
// device model plus directed timeout, mid-transfer send and reset sequences.
module tb_ps2_host_tx;

    localparam int unsigned INH      = 20;
    localparam int unsigned START_TO = 400;
    localparam int unsigned XFER_TO  = 2000;
    localparam int unsigned HALF     = 40;

    logic       CLOCK_50     = 1'b0;
    logic       reset        = 1'b1;
    logic       send_command = 1'b0;
    logic [7:0] command_data = 8'h00;
    logic       dev_clk_low  = 1'b0;
    logic       dev_dat_low  = 1'b0;
    logic       ps2_clk_in, ps2_dat_in;
    logic       clk_drive_low, dat_drive_low, busy, command_done, error;

    // Open-drain wired-AND of host and device pulls.
    assign ps2_clk_in = ~(clk_drive_low | dev_clk_low);
    assign ps2_dat_in = ~(dat_drive_low | dev_dat_low);

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO),
        .CNT_W               (20)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .send_command      (send_command),
        .command_data      (command_data),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_dat_in        (ps2_dat_in),
        .ps2_clk_drive_low (clk_drive_low),
        .ps2_dat_drive_low (dat_drive_low),
        .busy              (busy),
        .command_done      (command_done),
        .error             (error)
    );

    // Monitor, sampled on the falling system-clock edge.
    int cyc = 0, done_cnt = 0, err_cnt = 0, pulse_bad = 0;
    int err_cyc = 0, req_cyc = 0, rel_cyc = 0, inh_run = 0, inh_len = 0;
    int err_lines = 0;
    logic prev_busy = 1'b0, prev_dat_low = 1'b0, armed = 1'b0;

    always @(negedge CLOCK_50) begin
        cyc          <= cyc + 1;
        prev_busy    <= busy;
        prev_dat_low <= dat_drive_low;
        if (command_done) begin
            done_cnt <= done_cnt + 1;
            if (busy || !prev_busy) pulse_bad <= pulse_bad + 1;
        end
        if (error) begin
            err_cnt   <= err_cnt + 1;
            err_cyc   <= cyc;
            err_lines <= {30'd0, clk_drive_low, dat_drive_low};
            if (busy || !prev_busy) pulse_bad <= pulse_bad + 1;
        end
        if (clk_drive_low && !dat_drive_low) inh_run <= inh_run + 1;
        else inh_run <= 0;
        if (clk_drive_low && dat_drive_low) begin
            req_cyc <= cyc;
            inh_len <= inh_run;
            armed   <= 1'b1;
        end else if (armed && prev_dat_low && !dat_drive_low) begin
            rel_cyc <= cyc;
            armed   <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        command_data = b;
        send_command = 1'b1;
        @(negedge CLOCK_50);
        send_command = 1'b0;
    endtask

    // Device model: waits for request-to-send, generates n_edges clock pulses,
    // samples data on rising edges and optionally drives the ACK.
    task automatic dev_xfer(input int n_edges, input bit ack, output logic [7:0] data,
                            output logic par, output logic stop, output bit saw_req);
        int t = 0;
        data = 8'h00; par = 1'b0; stop = 1'b0; saw_req = 1'b0;
        while (!(ps2_clk_in == 1'b1 && ps2_dat_in == 1'b0) && t < 5000) begin
            @(negedge CLOCK_50);
            t++;
        end
        if (t >= 5000) return;
        saw_req = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLOCK_50);
            if (e <= 8) data[e-1] = ps2_dat_in;
            else if (e == 9) par = ps2_dat_in;
            else if (e == 10) stop = ps2_dat_in;
            dev_clk_low = 1'b0;
            if (e == 10 && ack) dev_dat_low = 1'b1;
            if (e == 11) dev_dat_low = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
        end
        dev_dat_low = 1'b0;
    endtask

    typedef struct {
        logic [7:0] cmd;
        bit         ack;
        logic [7:0] exp_data;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    localparam int NV = 4;
    vec_t vecs[NV];

    logic [7:0] got_data;
    logic       got_par, got_stop;
    bit         got_req;
    int         d0, e0, p0, t;

    initial begin
        vecs[0] = '{cmd: 8'hED, ack: 1'b1, exp_data: 8'hED, exp_par: 1'b1, exp_done: 1, exp_err: 0};
        vecs[1] = '{cmd: 8'hF4, ack: 1'b1, exp_data: 8'hF4, exp_par: 1'b0, exp_done: 1, exp_err: 0};
        vecs[2] = '{cmd: 8'h00, ack: 1'b1, exp_data: 8'h00, exp_par: 1'b1, exp_done: 1, exp_err: 0};
        vecs[3] = '{cmd: 8'hA5, ack: 1'b0, exp_data: 8'hA5, exp_par: 1'b1, exp_done: 0, exp_err: 1};

        repeat (5) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("reset clk_drive_low", int'(clk_drive_low), 0);
        check("reset dat_drive_low", int'(dat_drive_low), 0);
        check("reset busy", int'(busy), 0);
        check("reset command_done", int'(command_done), 0);
        check("reset error", int'(error), 0);

        for (int i = 0; i < NV; i++) begin
            d0 = done_cnt; e0 = err_cnt; p0 = pulse_bad;
            send(vecs[i].cmd);
            dev_xfer(11, vecs[i].ack, got_data, got_par, got_stop, got_req);
            repeat (3 * HALF) @(negedge CLOCK_50);
            check($sformatf("v%0d request seen", i), int'(got_req), 1);
            check($sformatf("v%0d inhibit cycles", i), inh_len, int'(INH));
            check($sformatf("v%0d data", i), int'(got_data), int'(vecs[i].exp_data));
            check($sformatf("v%0d parity", i), int'(got_par), int'(vecs[i].exp_par));
            check($sformatf("v%0d stop", i), int'(got_stop), 1);
            check($sformatf("v%0d done pulses", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("v%0d error pulses", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("v%0d busy at pulse", i), pulse_bad - p0, 0);
            check($sformatf("v%0d busy after", i), int'(busy), 0);
            check($sformatf("v%0d lines after", i), int'(clk_drive_low | dat_drive_low), 0);
        end

        // Device never clocks: start timeout.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h12);
        for (t = 0; t < int'(START_TO + INH + 100) && err_cnt == e0; t++) @(negedge CLOCK_50);
        repeat (5) @(negedge CLOCK_50);
        check("start timeout error", err_cnt - e0, 1);
        check("start timeout latency", err_cyc - req_cyc, int'(START_TO));
        check("start timeout lines", err_lines, 0);
        check("start timeout done", done_cnt - d0, 0);
        check("start timeout busy", int'(busy), 0);

        // Device stops after 5 edges: transfer timeout.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        dev_xfer(5, 1'b1, got_data, got_par, got_stop, got_req);
        for (t = 0; t < int'(XFER_TO + 100) && err_cnt == e0; t++) @(negedge CLOCK_50);
        repeat (5) @(negedge CLOCK_50);
        check("xfer timeout error", err_cnt - e0, 1);
        check("xfer timeout latency", err_cyc - rel_cyc, int'(XFER_TO));
        check("xfer timeout lines", err_lines, 0);
        check("xfer timeout done", done_cnt - d0, 0);

        // send_command re-asserted mid-transfer is ignored.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        fork
            dev_xfer(11, 1'b1, got_data, got_par, got_stop, got_req);
            begin
                repeat (INH + 300) @(negedge CLOCK_50);
                send(8'h00);
            end
        join
        repeat (3 * HALF) @(negedge CLOCK_50);
        check("midsend data", int'(got_data), 8'h3C);
        check("midsend parity", int'(got_par), 1);
        check("midsend done", done_cnt - d0, 1);
        check("midsend error", err_cnt - e0, 0);
        check("midsend no restart", int'(busy | clk_drive_low), 0);

        // Reset during SEND releases lines at once with no pulses.
        send(8'h5A);
        dev_xfer(4, 1'b1, got_data, got_par, got_stop, got_req);
        d0 = done_cnt; e0 = err_cnt;
        check("pre-reset busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("reset mid clk_drive_low", int'(clk_drive_low), 0);
        check("reset mid dat_drive_low", int'(dat_drive_low), 0);
        check("reset mid busy", int'(busy), 0);
        reset = 1'b0;
        repeat (XFER_TO + 100) @(negedge CLOCK_50);
        check("reset mid no done", done_cnt - d0, 0);
        check("reset mid no error", err_cnt - e0, 0);

        // Normal transfer after reset.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF);
        dev_xfer(11, 1'b1, got_data, got_par, got_stop, got_req);
        repeat (3 * HALF) @(negedge CLOCK_50);
        check("post-reset data", int'(got_data), 8'hFF);
        check("post-reset parity", int'(got_par), 1);
        check("post-reset done", done_cnt - d0, 1);
        check("post-reset error", err_cnt - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
